note_sequencer: RTL and testbench

Sequences queued notes into the synthesizer datapath. The block buffers note commands {tuneWord, volume, duration} in a small FIFO and drives the waveGen `tuneWord` and the volume input on wave-gen tick boundaries. It ramps volume up and down linearly so that frequency changes always happen at zero volume, which keeps the output click-free. It sits between the SPI command decoder and the waveGen/multiplier stage, and advances only on the 156.25 kHz `wgEn` strobe.

---
 rtl/note_seq_pkg.sv | 20 ++
 rtl/note_fifo.sv | 56 +++++
 rtl/note_sequencer.sv | 126 ++++++++++++
 tb/tb_note_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_seq_pkg.sv
// rtl/note_seq_pkg.sv - shared types and defaults for the note sequencer
package note_seq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        HOLD      = 2'd2,
        RAMP_DOWN = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [15:0] tune;
        logic [7:0]  vol;
        logic [15:0] dur;
    } note_cmd_t;

    localparam int DEF_DEPTH     = 4;
    localparam int DEF_RAMP_STEP = 4;

endpackage

// File: rtl/note_fifo.sv
// rtl/note_fifo.sv - small synchronous FIFO of note commands with flush
module note_fifo
    import note_seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  note_cmd_t                push_data,
    input  logic                     pop,
    output note_cmd_t                head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    note_cmd_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - queues notes and ramps volume so tune changes happen at zero volume
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int RAMP_STEP = DEF_RAMP_STEP
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [15:0]              cmd_tune,
    input  logic [7:0]               cmd_vol,
    input  logic [15:0]              cmd_dur,
    input  logic                     flush,
    output logic [15:0]              tuneWord,
    output logic [7:0]               volume,
    output logic                     playing,
    output logic                     note_done,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam logic [8:0] STEP9 = 9'(RAMP_STEP);

    seq_state_t  state, state_n;
    logic [15:0] tune_n;
    logic [7:0]  vol_n, target, target_n;
    logic [15:0] dur_cnt, dur_n;
    logic        done_n;
    logic        pop, full, empty;
    note_cmd_t   head, push_data;
    logic [8:0]  up_sum, dn_diff;
    logic [7:0]  up_val, dn_val;

    assign cmd_ready = ~full & ~flush & ~reset;
    assign playing   = (state != IDLE);
    assign push_data = '{tune: cmd_tune, vol: cmd_vol, dur: cmd_dur};

    note_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (cmd_valid & cmd_ready),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (full),
        .empty     (empty)
    );

    // Ramp steps saturate at the target / at zero; the 9th bit catches overflow and underflow.
    always_comb begin
        up_sum  = {1'b0, volume} + STEP9;
        up_val  = (up_sum > {1'b0, target}) ? target : up_sum[7:0];
        dn_diff = {1'b0, volume} - STEP9;
        dn_val  = dn_diff[8] ? 8'd0 : dn_diff[7:0];
    end

    always_comb begin
        state_n  = state;
        tune_n   = tuneWord;
        vol_n    = volume;
        target_n = target;
        dur_n    = dur_cnt;
        done_n   = 1'b0;
        pop      = 1'b0;
        if (flush) begin
            if (state == RAMP_UP || state == HOLD) begin
                state_n = RAMP_DOWN;
            end
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        pop      = 1'b1;
                        tune_n   = head.tune;
                        target_n = head.vol;
                        dur_n    = head.dur;
                        state_n  = RAMP_UP;
                    end
                end
                RAMP_UP: begin
                    vol_n = up_val;
                    if (up_val == target) begin
                        state_n = HOLD;
                    end
                end
                HOLD: begin
                    if (dur_cnt == '0) begin
                        done_n  = 1'b1;
                        state_n = RAMP_DOWN;
                    end else begin
                        dur_n = dur_cnt - 16'd1;
                    end
                end
                RAMP_DOWN: begin
                    vol_n = dn_val;
                    if (dn_val == '0) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tuneWord  <= '0;
            volume    <= '0;
            target    <= '0;
            dur_cnt   <= '0;
            note_done <= 1'b0;
        end else begin
            state     <= state_n;
            tuneWord  <= tune_n;
            volume    <= vol_n;
            target    <= target_n;
            dur_cnt   <= dur_n;
            note_done <= done_n;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - self-checking bench for note_sequencer
module tb_note_sequencer;
    localparam int DEPTH = 4;
    localparam int STEP  = 4;

    logic        clk = 1'b0;
    logic        reset, tick, cmd_valid, flush;
    logic        cmd_ready, playing, note_done;
    logic [15:0] cmd_tune, cmd_dur, tuneWord;
    logic [7:0]  cmd_vol, volume;
    logic [2:0]  fifo_count;

    int n_cmp  = 0;
    int n_fail = 0;

    note_sequencer #(.DEPTH(DEPTH), .RAMP_STEP(STEP)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_tune   (cmd_tune),
        .cmd_vol    (cmd_vol),
        .cmd_dur    (cmd_dur),
        .flush      (flush),
        .tuneWord   (tuneWord),
        .volume     (volume),
        .playing    (playing),
        .note_done  (note_done),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int vol;
        int done;
        int playing;
    } trace_t;

    typedef struct {
        int vol;
        int dur;
        int ticks;
        int peak;
    } life_t;

    trace_t tr [13];
    life_t  lt [6];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // One gap cycle, then a one-cycle tick; returns just after the tick edge.
    task automatic do_tick();
        idle_cycle();
        tick = 1'b1;
        idle_cycle();
        tick = 1'b0;
    endtask

    task automatic push(input logic [15:0] t, input logic [7:0] v, input logic [15:0] d);
        cmd_valid = 1'b1;
        cmd_tune  = t;
        cmd_vol   = v;
        cmd_dur   = d;
        idle_cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic run_single();
        push(16'h1000, 8'h10, 16'd3);
        chk("single_count_after_push", fifo_count, 1);
        for (int i = 0; i < 13; i++) begin
            do_tick();
            chk($sformatf("single_vol_t%0d", i + 1), volume, tr[i].vol);
            chk($sformatf("single_done_t%0d", i + 1), note_done, tr[i].done);
            chk($sformatf("single_play_t%0d", i + 1), playing, tr[i].playing);
            chk($sformatf("single_tune_t%0d", i + 1), tuneWord, 16'h1000);
            if (tr[i].done != 0) begin
                idle_cycle();
                chk("single_done_one_cycle", note_done, 0);
            end
        end
        chk("single_count_end", fifo_count, 0);
    endtask

    // Reference: a note is a sequence of per-tick volumes built from the ramp/hold rules.
    task automatic run_batch(input int n);
        logic [15:0] tq [$];
        int vq [$], dq [$];
        int ev [$], et [$], ed [$], ec [$];
        int v, vt, dur;
        logic [15:0] last_tune;
        last_tune = tuneWord;
        for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 3))
                0:       vt = 0;
                1:       vt = 250 + $urandom_range(0, 5);
                default: vt = $urandom_range(1, 255);
            endcase
            tq.push_back(16'($urandom_range(1, 16'hFFFF)));
            vq.push_back(vt);
            dq.push_back($urandom_range(0, 4));
            chk("batch_ready", cmd_ready, 1);
            push(tq[k], 8'(vt), 16'(dq[k]));
        end
        chk("batch_count", fifo_count, n);
        for (int k = 0; k < n; k++) begin
            vt = vq[k];
            dur = dq[k];
            last_tune = tq[k];
            ev.push_back(0); et.push_back(last_tune); ed.push_back(0); ec.push_back(n - k - 1);
            v = 0;
            do begin
                v = (v + STEP > vt) ? vt : v + STEP;
                ev.push_back(v); et.push_back(last_tune); ed.push_back(0); ec.push_back(n - k - 1);
            end while (v != vt);
            for (int h = 0; h <= dur; h++) begin
                ev.push_back(vt); et.push_back(last_tune); ed.push_back(h == dur); ec.push_back(n - k - 1);
            end
            do begin
                v = (v < STEP) ? 0 : v - STEP;
                ev.push_back(v); et.push_back(last_tune); ed.push_back(0); ec.push_back(n - k - 1);
            end while (v != 0);
        end
        for (int k = 0; k < 2; k++) begin
            ev.push_back(0); et.push_back(last_tune); ed.push_back(0); ec.push_back(0);
        end
        foreach (ev[i]) begin
            do_tick();
            chk("rand_vol", volume, ev[i]);
            chk("rand_tune", tuneWord, et[i]);
            chk("rand_done", note_done, ed[i]);
            chk("rand_count", fifo_count, ec[i]);
        end
        chk("rand_idle", playing, 0);
    endtask

    logic [15:0] prev_tune = '0;
    always @(negedge clk) begin
        if (!reset && tuneWord != prev_tune) begin
            chk("tune_change_at_zero_volume", volume, 0);
        end
        prev_tune = tuneWord;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, peak, dones;
        tr[0]  = '{0, 0, 1};  tr[1]  = '{4, 0, 1};  tr[2]  = '{8, 0, 1};
        tr[3]  = '{12, 0, 1}; tr[4]  = '{16, 0, 1}; tr[5]  = '{16, 0, 1};
        tr[6]  = '{16, 0, 1}; tr[7]  = '{16, 0, 1}; tr[8]  = '{16, 1, 1};
        tr[9]  = '{12, 0, 1}; tr[10] = '{8, 0, 1};  tr[11] = '{4, 0, 1};
        tr[12] = '{0, 0, 0};
        lt[0] = '{16, 3, 13, 16};
        lt[1] = '{254, 0, 130, 254};
        lt[2] = '{0, 2, 6, 0};
        lt[3] = '{5, 0, 6, 5};
        lt[4] = '{255, 1, 131, 255};
        lt[5] = '{4, 0, 4, 4};

        reset = 1'b1; tick = 1'b0; cmd_valid = 1'b0; flush = 1'b0;
        cmd_tune = '0; cmd_vol = '0; cmd_dur = '0;
        repeat (3) idle_cycle();
        chk("reset_tune", tuneWord, 0);
        chk("reset_vol", volume, 0);
        chk("reset_playing", playing, 0);
        chk("reset_done", note_done, 0);
        chk("reset_count", fifo_count, 0);
        chk("reset_ready", cmd_ready, 0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", cmd_ready, 1);

        run_single();

        foreach (lt[i]) begin
            push(16'h5000 + 16'(i), 8'(lt[i].vol), 16'(lt[i].dur));
            n = 0; peak = 0; dones = 0;
            for (int t = 0; t < 300; t++) begin
                do_tick();
                n++;
                if (volume > peak) peak = volume;
                if (note_done) dones++;
                if (!playing) break;
            end
            chk($sformatf("life%0d_ticks", i), n, lt[i].ticks);
            chk($sformatf("life%0d_peak", i), peak, lt[i].peak);
            chk($sformatf("life%0d_dones", i), dones, 1);
            chk($sformatf("life%0d_endvol", i), volume, 0);
        end

        // Back-to-back notes: exactly one zero-volume IDLE tick before the second load.
        push(16'h1000, 8'd8, 16'd0);
        push(16'h2000, 8'd8, 16'd0);
        repeat (6) do_tick();
        chk("b2b_gap_vol", volume, 0);
        chk("b2b_gap_playing", playing, 0);
        chk("b2b_gap_tune", tuneWord, 16'h1000);
        do_tick();
        chk("b2b_load_tune", tuneWord, 16'h2000);
        chk("b2b_load_vol", volume, 0);
        chk("b2b_load_playing", playing, 1);
        repeat (12) do_tick();
        chk("b2b_end_playing", playing, 0);

        // Full FIFO: fifth push is refused.
        for (int k = 0; k < 5; k++) begin
            push(16'h0100 + 16'(k), 8'd1, 16'd0);
            if (k == 3) begin
                chk("full_ready_low", cmd_ready, 0);
                chk("full_count4", fifo_count, 4);
            end
        end
        chk("full_count_after5", fifo_count, 4);
        flush = 1'b1;
        idle_cycle();
        flush = 1'b0;
        chk("full_flushed", fifo_count, 0);

        // Flush mid-HOLD, coincident with tick and a push.
        push(16'h3000, 8'h10, 16'd20);
        push(16'h3100, 8'h20, 16'd1);
        repeat (7) do_tick();
        chk("flush_pre_vol", volume, 16);
        idle_cycle();
        flush = 1'b1; tick = 1'b1; cmd_valid = 1'b1; cmd_tune = 16'h3200;
        idle_cycle();
        flush = 1'b0; tick = 1'b0; cmd_valid = 1'b0;
        chk("flush_count", fifo_count, 0);
        chk("flush_vol_held", volume, 16);
        chk("flush_playing", playing, 1);
        chk("flush_no_done", note_done, 0);
        n = 0; dones = 0;
        for (int t = 0; t < 20; t++) begin
            do_tick();
            n++;
            if (note_done) dones++;
            if (!playing) break;
        end
        chk("flush_down_ticks", n, 4);
        chk("flush_dones", dones, 0);
        chk("flush_end_vol", volume, 0);
        repeat (2) do_tick();
        chk("flush_stays_idle", playing, 0);
        chk("flush_tune_held", tuneWord, 16'h3000);

        // Reset during RAMP_UP, then a clean replay.
        push(16'h4000, 8'h40, 16'd1);
        repeat (3) do_tick();
        chk("rst_pre_vol", volume, 8);
        reset = 1'b1;
        idle_cycle();
        chk("rst_tune", tuneWord, 0);
        chk("rst_vol", volume, 0);
        chk("rst_playing", playing, 0);
        chk("rst_done", note_done, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", cmd_ready, 0);
        reset = 1'b0;
        #1;
        run_single();

        for (int b = 0; b < 6; b++) begin
            run_batch($urandom_range(1, DEPTH));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
